// File: rtl/mem_interface.sv
// CPU-side memory interface: turns MAR/MDR read/write requests into a registered
// mem_rd/mem_wr + mem_ack handshake. Define MEM_TIMEOUT_EN to abort transfers after TIMEOUT cycles.
module mem_interface #(
  parameter int unsigned ADDR_W  = 9,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              rd_req,
  input  logic              wr_req,
  input  logic [31:0]       mar_in,
  input  logic [31:0]       mdr_in,
  output logic [31:0]       mdatain,
  output logic              mdr_load,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              mem_rd,
  output logic              mem_wr,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ack
);

  typedef enum logic [1:0] {StIdle, StRdWait, StWrWait} state_e;

  // Address bits above the memory's word range; any of them set is an out-of-range access.
  localparam logic [31:0] HiMask = ~((32'd1 << ADDR_W) - 32'd1);

  state_e state;
  logic   addr_oob;

  assign addr_oob = |(mar_in & HiMask);

`ifdef MEM_TIMEOUT_EN
  localparam logic [7:0] TimeoutLast = 8'(TIMEOUT - 1);
  logic [7:0] wait_cnt;
`else
  logic [31:0] unused_timeout;
  assign unused_timeout = TIMEOUT;
`endif

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state     <= StIdle;
      mdatain   <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_rd    <= 1'b0;
      mem_wr    <= 1'b0;
      mdr_load  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
`ifdef MEM_TIMEOUT_EN
      wait_cnt  <= '0;
`endif
    end else begin
      done     <= 1'b0;
      mdr_load <= 1'b0;
      case (state)
        StIdle: begin
`ifdef MEM_TIMEOUT_EN
          wait_cnt <= '0;
`endif
          if (rd_req || wr_req) begin
            if (addr_oob) begin
              err  <= 1'b1;
              done <= 1'b1;
            end else begin
              err      <= 1'b0;
              busy     <= 1'b1;
              mem_addr <= mar_in[ADDR_W-1:0];
              // Read wins when both requests arrive together; the write is dropped.
              if (rd_req) begin
                mem_rd <= 1'b1;
                state  <= StRdWait;
              end else begin
                mem_wdata <= mdr_in;
                mem_wr    <= 1'b1;
                state     <= StWrWait;
              end
            end
          end
        end

        StRdWait: begin
          if (mem_ack) begin
            mdatain  <= mem_rdata;
            mem_rd   <= 1'b0;
            mdr_load <= 1'b1;
            done     <= 1'b1;
            busy     <= 1'b0;
            state    <= StIdle;
          end
`ifdef MEM_TIMEOUT_EN
          else if (wait_cnt == TimeoutLast) begin
            mem_rd <= 1'b0;
            err    <= 1'b1;
            done   <= 1'b1;
            busy   <= 1'b0;
            state  <= StIdle;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
`endif
        end

        StWrWait: begin
          if (mem_ack) begin
            mem_wr <= 1'b0;
            done   <= 1'b1;
            busy   <= 1'b0;
            state  <= StIdle;
          end
`ifdef MEM_TIMEOUT_EN
          else if (wait_cnt == TimeoutLast) begin
            mem_wr <= 1'b0;
            err    <= 1'b1;
            done   <= 1'b1;
            busy   <= 1'b0;
            state  <= StIdle;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
`endif
        end

        default: begin
          mem_rd <= 1'b0;
          mem_wr <= 1'b0;
          busy   <= 1'b0;
          state  <= StIdle;
        end
      endcase
    end
  end

endmodule
